// File: rtl/multiplier_sweep_checker.sv
// Self-test sweeper for a combinational multiplier: drives every (A,B) pair,
// waits a settle window, compares the returned product to a golden A*B and
// reports mismatch statistics plus the first failing vector.
//
// Handshake: `start` is a one-cycle request, accepted only in IDLE or FIN and
// only when `abort` is low in the same cycle. `abort` is honoured only while
// busy (APPLY/CHECK). `done`/`pass` are levels that stay valid until the next
// accepted start or reset.
module multiplier_sweep_checker #(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_p,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [2*WIDTH:0]     vec_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2*WIDTH-1:0]   fail_p,
  output logic                 fail_valid,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_settle;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err;
  logic [PW:0]      r_vec;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [PW-1:0]    r_fail_p;
  logic             r_fail_valid;

  logic [PW-1:0]    w_gold;
  logic             w_mismatch;
  logic             w_last;
  logic [CNT_W-1:0] w_err_next;

  // Golden product, compare result and saturating error increment for the CHECK cycle.
  always_comb begin
    w_gold     = PW'(r_a) * PW'(r_b);
    w_mismatch = (mult_p != w_gold);
    w_last     = (&r_a) && (&r_b);
    w_err_next = r_err;
    if (w_mismatch && (r_err != ERR_MAX)) begin
      w_err_next = r_err + 1'b1;
    end
  end

  // Sweep FSM: owns operands, status flags, counters and first-failure capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_settle     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_vec        <= '0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_p     <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, FIN: begin
          if (start && !abort) begin
            r_err        <= '0;
            r_vec        <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_p     <= '0;
            r_fail_valid <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_busy       <= 1'b1;
            r_settle     <= '0;
            r_state      <= APPLY;
          end
        end
        APPLY: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else if (r_settle == SETTLE_LAST) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        CHECK: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_err <= w_err_next;
            r_vec <= r_vec + 1'b1;
            if (w_mismatch && !r_fail_valid) begin
              r_fail_a     <= r_a;
              r_fail_b     <= r_b;
              r_fail_p     <= mult_p;
              r_fail_valid <= 1'b1;
            end
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
              r_state <= FIN;
            end else begin
              // B is the inner loop; A steps when B wraps back to zero.
              r_b      <= r_b + 1'b1;
              if (&r_b) begin
                r_a <= r_a + 1'b1;
              end
              r_settle <= '0;
              r_state  <= APPLY;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mult_a     = r_a;
  assign mult_b     = r_b;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign vec_count  = r_vec;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;
  assign fail_p     = r_fail_p;
  assign fail_valid = r_fail_valid;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_multiplier_sweep_checker.sv
// Bench for multiplier_sweep_checker: a behavioural multiplier with selectable
// faults sits in the loop, a scoreboard tracks the expected operand sequence,
// and scenario tasks check timing, statistics, restart, abort and reset.
module tb_multiplier_sweep_checker;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // main DUT signals
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mult_a, mult_b;
  logic [3:0] mult_p;
  logic       busy, done, pass, fail_valid;
  logic [7:0] err_count;
  logic [4:0] vec_count;
  logic [1:0] fail_a, fail_b;
  logic [3:0] fail_p;
  logic [1:0] dbg_state;

  // multiplier under test: 0 = correct, 1 = product bit0 stuck at 0
  int         fault_mode = 0;
  logic [3:0] w_true_p;
  assign w_true_p = {2'b00, mult_a} * {2'b00, mult_b};
  assign mult_p   = (fault_mode == 1) ? (w_true_p & 4'b1110) : w_true_p;

  multiplier_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_count(vec_count), .fail_a(fail_a), .fail_b(fail_b), .fail_p(fail_p),
    .fail_valid(fail_valid), .dbg_state(dbg_state)
  );

  // second instance: product tied to zero, 2-bit saturating error counter
  logic       s_start = 1'b0;
  logic       s_abort = 1'b0;
  logic [1:0] s_a, s_b, s_fail_a, s_fail_b;
  logic       s_busy, s_done, s_pass, s_fail_valid;
  logic [1:0] s_err;
  logic [4:0] s_vec;
  logic [3:0] s_fail_p;
  logic [1:0] s_dbg;

  multiplier_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .mult_a(s_a), .mult_b(s_b), .mult_p(4'd0),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .vec_count(s_vec), .fail_a(s_fail_a), .fail_b(s_fail_b), .fail_p(s_fail_p),
    .fail_valid(s_fail_valid), .dbg_state(s_dbg)
  );

  // scoreboard: expected {A,B} for each CHECK cycle, in sweep order
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  always @(negedge clk) begin
    if (!rst && dbg_state == ST_CHECK) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra_vector: got a=%0d b=%0d, expected no more vectors", mult_a, mult_b);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mult_a, mult_b} !== mon_exp) begin
          failures++;
          $display("FAIL sb_operands: got a=%0d b=%0d, expected a=%0d b=%0d",
                   mult_a, mult_b, mon_exp[3:2], mon_exp[1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_sweep();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({a[1:0], b[1:0]});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // counts edges after the start edge until done is seen; cyc starts at cyc0
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, expected 1", done, cyc);
    end
  endtask

  // model of the expected error statistics for a given fault mode
  task automatic model_sweep(input int mode, input int cnt_max, output int errs,
                             output bit fv, output logic [1:0] fa, output logic [1:0] fb,
                             output logic [3:0] fp);
    logic [3:0] good, obs;
    errs = 0; fv = 0; fa = '0; fb = '0; fp = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        good = 4'(a * b);
        obs  = (mode == 1) ? (good & 4'b1110) : (mode == 2) ? 4'd0 : good;
        if (obs != good) begin
          if (errs < cnt_max) errs++;
          if (!fv) begin
            fv = 1; fa = a[1:0]; fb = b[1:0]; fp = obs;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, fail_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/pass/fv=%b, expected 0000", {busy, done, pass, fail_valid});
    end
    checks++;
    if ({err_count, vec_count, mult_a, mult_b} !== '0) begin
      failures++;
      $display("FAIL reset_counts: err=%0d vec=%0d a=%0d b=%0d, expected all 0", err_count, vec_count, mult_a, mult_b);
    end
    checks++;
    if ({fail_a, fail_b, fail_p, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_fail_regs: fa=%0d fb=%0d fp=%0d st=%0d, expected all 0", fail_a, fail_b, fail_p, dbg_state);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_golden();
    int cyc;
    fault_mode = 0;
    push_sweep();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_APPLY || mult_a !== 2'd0 || mult_b !== 2'd0) begin
      failures++;
      $display("FAIL golden_launch: busy=%0b st=%0d a=%0d b=%0d, expected 1 %0d 0 0", busy, dbg_state, mult_a, mult_b, ST_APPLY);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc !== 32) begin
      failures++;
      $display("FAIL golden_latency: done after %0d cycles, expected 32", cyc);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 8'd0 || vec_count !== 5'd16 || fail_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL golden_result: pass=%0b err=%0d vec=%0d fv=%0b busy=%0b, expected 1 0 16 0 0",
               pass, err_count, vec_count, fail_valid, busy);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL golden_sb_drain: %0d vectors unchecked, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stuck_bit0();
    int cyc, m_err;
    bit m_fv;
    logic [1:0] m_fa, m_fb;
    logic [3:0] m_fp;
    model_sweep(1, 255, m_err, m_fv, m_fa, m_fb, m_fp);
    fault_mode = 1;
    push_sweep();
    pulse_start();
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || err_count !== 8'd0 || vec_count !== 5'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_from_fin: done=%0b pass=%0b err=%0d vec=%0d busy=%0b, expected 0 0 0 0 1",
               done, pass, err_count, vec_count, busy);
    end
    wait_done(0, cyc);
    checks++;
    if (err_count !== 8'(m_err) || pass !== 1'b0 || vec_count !== 5'd16) begin
      failures++;
      $display("FAIL stuck_result: err=%0d pass=%0b vec=%0d, expected %0d 0 16", err_count, pass, vec_count, m_err);
    end
    checks++;
    if (fail_valid !== m_fv || fail_a !== m_fa || fail_b !== m_fb || fail_p !== m_fp) begin
      failures++;
      $display("FAIL stuck_first_fail: fv=%0b a=%0d b=%0d p=%0d, expected %0b %0d %0d %0d",
               fail_valid, fail_a, fail_b, fail_p, m_fv, m_fa, m_fb, m_fp);
    end
    fault_mode = 0;
  endtask

  task automatic test_saturate();
    int cyc, m_err;
    bit m_fv;
    logic [1:0] m_fa, m_fb;
    logic [3:0] m_fp;
    model_sweep(2, 3, m_err, m_fv, m_fa, m_fb, m_fp);
    @(negedge clk) s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    cyc = 0;
    while (cyc < 200 && !s_done) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    checks++;
    if (s_done !== 1'b1 || cyc !== 32) begin
      failures++;
      $display("FAIL sat_done: done=%0b after %0d cycles, expected 1 after 32", s_done, cyc);
    end
    checks++;
    if (s_err !== 2'(m_err) || s_pass !== 1'b0 || s_vec !== 5'd16) begin
      failures++;
      $display("FAIL sat_result: err=%0d pass=%0b vec=%0d, expected %0d 0 16", s_err, s_pass, s_vec, m_err);
    end
    checks++;
    if (s_fail_valid !== m_fv || s_fail_a !== m_fa || s_fail_b !== m_fb || s_fail_p !== m_fp) begin
      failures++;
      $display("FAIL sat_first_fail: fv=%0b a=%0d b=%0d p=%0d, expected %0b %0d %0d %0d",
               s_fail_valid, s_fail_a, s_fail_b, s_fail_p, m_fv, m_fa, m_fb, m_fp);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    push_sweep();
    pulse_start();
    repeat (9) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(10, cyc);
    checks++;
    if (cyc !== 32 || vec_count !== 5'd16 || pass !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_ignored: done at %0d vec=%0d pass=%0b, expected 32 16 1", cyc, vec_count, pass);
    end
  endtask

  task automatic test_abort();
    int cyc;
    push_sweep();
    pulse_start();
    repeat (10) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_count !== 5'd5 || mult_a !== 2'd1 || mult_b !== 2'd1) begin
      failures++;
      $display("FAIL abort_state: busy=%0b done=%0b vec=%0d a=%0d b=%0d, expected 0 0 5 1 1",
               busy, done, vec_count, mult_a, mult_b);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || vec_count !== 5'd5 || mult_a !== 2'd1 || mult_b !== 2'd1 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL abort_hold: st=%0d vec=%0d a=%0d b=%0d err=%0d, expected 0 5 1 1 0",
               dbg_state, vec_count, mult_a, mult_b, err_count);
    end
    checks++;
    if (exp_q.size() !== 11) begin
      failures++;
      $display("FAIL abort_sb_count: %0d vectors left, expected 11", exp_q.size());
    end
    exp_q.delete();
    // abort in IDLE is inert and beats a simultaneous start
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE || vec_count !== 5'd5) begin
      failures++;
      $display("FAIL abort_start_idle: busy=%0b st=%0d vec=%0d, expected 0 0 5", busy, dbg_state, vec_count);
    end
    push_sweep();
    pulse_start();
    checks++;
    if (vec_count !== 5'd0 || mult_a !== 2'd0 || mult_b !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart: vec=%0d a=%0d b=%0d busy=%0b, expected 0 0 0 1", vec_count, mult_a, mult_b, busy);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc !== 32 || pass !== 1'b1 || vec_count !== 5'd16) begin
      failures++;
      $display("FAIL abort_resweep: done at %0d pass=%0b vec=%0d, expected 32 1 16", cyc, pass, vec_count);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    fault_mode = 1;
    push_sweep();
    pulse_start();
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, fail_valid, err_count, vec_count, mult_a, mult_b, fail_a, fail_b, fail_p, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_async: busy=%0b done=%0b err=%0d vec=%0d a=%0d b=%0d fv=%0b st=%0d, expected all 0",
               busy, done, err_count, vec_count, mult_a, mult_b, fail_valid, dbg_state);
    end
    exp_q.delete();
    fault_mode = 0;
    @(negedge clk) rst = 1'b0;
    push_sweep();
    pulse_start();
    wait_done(0, cyc);
    checks++;
    if (cyc !== 32 || pass !== 1'b1 || err_count !== 8'd0 || vec_count !== 5'd16 || fail_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_resweep: done at %0d pass=%0b err=%0d vec=%0d fv=%0b, expected 32 1 0 16 0",
               cyc, pass, err_count, vec_count, fail_valid);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck_bit0();
    test_saturate();
    test_start_while_busy();
    test_abort();
    test_reset_mid_sweep();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
